// File: rtl/shadow_centroid_pkg.sv
// Shared types and constants for the shadow centroid / shadow length path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shadow_centroid_pkg;

    // Coordinate widths shared with the downstream length stage.
    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int ACC_W = 32;

    // Centre-of-frame fallback coordinates for unreliable centroids.
    localparam logic [X_W-1:0] X_DEFAULT_C = 11'd512;
    localparam logic [Y_W-1:0] Y_DEFAULT_C = 10'd384;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Saturate a 32-bit quotient into the coordinate range before narrowing.
    function automatic logic [X_W-1:0] clamp_x(input logic [ACC_W-1:0] q);
        if (q > 32'd2047) begin
            return '1;
        end
        return q[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [ACC_W-1:0] q);
        if (q > 32'd1023) begin
            return '1;
        end
        return q[Y_W-1:0];
    endfunction

endpackage

// File: rtl/shadow_centroid_div.sv
// Unsigned restoring divider, one quotient bit per clock, one divide in flight.
// Latency: data_valid_out rises 33 cycles after data_valid_in (WIDTH=32); zero divisor flags error_out next cycle.
// Backpressure: none; a new data_valid_in restarts the divider, the caller must wait for completion.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   dividend_in, divisor_in   operands, sampled with data_valid_in
//   data_valid_in             start a divide
//   quotient_out              floor(dividend / divisor), valid with data_valid_out
//   data_valid_out            one-cycle completion pulse
//   error_out                 one-cycle pulse instead of data_valid_out on divide-by-zero
module shadow_centroid_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             data_valid_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             data_valid_out,
    output logic             error_out
);

    localparam int CW = $clog2(WIDTH);

    logic             running;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;

    // The dividend is shifted out of the top of quo into the partial
    // remainder while quotient bits are shifted in at the bottom. The
    // remainder is always below the divisor, so the trial value fits in
    // WIDTH+1 bits and the WIDTH-bit subtract cannot wrap.
    always_comb begin
        trial   = {rem, quo[WIDTH-1]};
        fits    = (trial >= {1'b0, dvs});
        rem_nxt = fits ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            running        <= 1'b0;
            count          <= '0;
            quo            <= '0;
            rem            <= '0;
            dvs            <= '0;
            data_valid_out <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            error_out      <= 1'b0;
            if (data_valid_in) begin
                if (divisor_in == '0) begin
                    running   <= 1'b0;
                    error_out <= 1'b1;
                end else begin
                    quo     <= dividend_in;
                    rem     <= '0;
                    dvs     <= divisor_in;
                    count   <= '0;
                    running <= 1'b1;
                end
            end else if (running) begin
                rem   <= rem_nxt;
                quo   <= {quo[WIDTH-2:0], fits};
                count <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    running        <= 1'b0;
                    data_valid_out <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = quo;

endmodule

// File: rtl/shadow_centroid.sv
// Per-frame shadow centroid: sums masked pixel coordinates, divides by count at frame end.
// Latency: tabulate_in to valid_out is 2 cycles for low mass, else 2 divider latencies + 3.
// Backpressure: none; pixels and tabulate_in are dropped while busy_out is high.
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   x_in, y_in         pixel column / row
//   valid_in           pixel is shadow, accumulate it
//   tabulate_in        frame-end strobe, compute the centroid
//   x_out, y_out       centroid, held until the next result
//   mass_out           shadow pixel count of the frame
//   valid_out          one-cycle pulse when outputs are new
//   busy_out           high while a tabulation is in progress
module shadow_centroid
    import shadow_centroid_pkg::*;
#(
    parameter logic [ACC_W-1:0] MIN_MASS  = 32'd16,
    parameter logic [X_W-1:0]   X_DEFAULT = X_DEFAULT_C,
    parameter logic [Y_W-1:0]   Y_DEFAULT = Y_DEFAULT_C
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [X_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_in,
    input  logic             valid_in,
    input  logic             tabulate_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [ACC_W-1:0] mass_out,
    output logic             valid_out,
    output logic             busy_out
);

    state_t state, state_nxt;

    logic [ACC_W-1:0] sum_x, sum_y, mass;
    logic [ACC_W-1:0] lat_sum_x, lat_sum_y, lat_mass;
    logic [ACC_W-1:0] fin_x, fin_y, fin_mass;
    logic             low_mass;
    logic [X_W-1:0]   x_res;
    logic [Y_W-1:0]   y_res;

    logic             div_start;
    logic             div_second;
    logic             div_vld_in;
    logic [ACC_W-1:0] div_dividend;
    logic [ACC_W-1:0] div_q;
    logic             div_vld_out;
    logic             div_err;

    // Frame totals including a pixel that arrives together with tabulate_in.
    always_comb begin
        fin_x    = sum_x + (valid_in ? ACC_W'(x_in) : '0);
        fin_y    = sum_y + (valid_in ? ACC_W'(y_in) : '0);
        fin_mass = mass + (valid_in ? ACC_W'(1) : '0);
        low_mass = (fin_mass < MIN_MASS);
    end

    // x divide starts from a registered strobe the cycle after tabulation;
    // the y divide is chained straight off the x completion so the divider
    // never idles between the two.
    always_comb begin
        div_second   = (state == DIV_X) && div_vld_out && !div_err;
        div_vld_in   = div_start || div_second;
        div_dividend = div_second ? lat_sum_y : lat_sum_x;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (tabulate_in) begin
                    state_nxt = low_mass ? OUTPUT : DIV_X;
                end
            end
            DIV_X: begin
                if (div_err) begin
                    state_nxt = OUTPUT;
                end else if (div_vld_out) begin
                    state_nxt = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_err || div_vld_out) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                state_nxt = ACCUM;
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_x     <= '0;
            sum_y     <= '0;
            mass      <= '0;
            lat_sum_x <= '0;
            lat_sum_y <= '0;
            lat_mass  <= '0;
            x_res     <= '0;
            y_res     <= '0;
            div_start <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            mass_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            div_start <= 1'b0;
            valid_out <= 1'b0;
            case (state)
                ACCUM: begin
                    if (tabulate_in) begin
                        lat_sum_x <= fin_x;
                        lat_sum_y <= fin_y;
                        lat_mass  <= fin_mass;
                        sum_x     <= '0;
                        sum_y     <= '0;
                        mass      <= '0;
                        if (low_mass) begin
                            x_res <= X_DEFAULT;
                            y_res <= Y_DEFAULT;
                        end else begin
                            div_start <= 1'b1;
                        end
                    end else begin
                        sum_x <= fin_x;
                        sum_y <= fin_y;
                        mass  <= fin_mass;
                    end
                end
                DIV_X: begin
                    if (div_err) begin
                        x_res <= X_DEFAULT;
                        y_res <= Y_DEFAULT;
                    end else if (div_vld_out) begin
                        x_res <= clamp_x(div_q);
                    end
                end
                DIV_Y: begin
                    if (div_err) begin
                        x_res <= X_DEFAULT;
                        y_res <= Y_DEFAULT;
                    end else if (div_vld_out) begin
                        y_res <= clamp_y(div_q);
                    end
                end
                OUTPUT: begin
                    x_out     <= x_res;
                    y_out     <= y_res;
                    mass_out  <= lat_mass;
                    valid_out <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_out = (state != ACCUM);

    shadow_centroid_div #(
        .WIDTH (ACC_W)
    ) u_div (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .dividend_in    (div_dividend),
        .divisor_in     (lat_mass),
        .data_valid_in  (div_vld_in),
        .quotient_out   (div_q),
        .data_valid_out (div_vld_out),
        .error_out      (div_err)
    );

endmodule

// File: tb/tb_shadow_centroid.sv
// Bench for shadow_centroid: default instance (a_*) and a MIN_MASS=1 instance (b_*).
// Frames are built as pixel lists; expected centroid/mass/latency come from plain arithmetic.
// Divider completes 33 cycles after its start, so a full tabulation takes 2*33+3 cycles.
module tb_shadow_centroid;

    localparam int DIV_LAT = 33;
    localparam int BOUND   = 200;

    logic        clk_in = 1'b0;
    logic        rst_in;

    logic [10:0] a_x, b_x;
    logic [9:0]  a_y, b_y;
    logic        a_vld, b_vld, a_tab, b_tab;
    logic [10:0] a_x_out, b_x_out;
    logic [9:0]  a_y_out, b_y_out;
    logic [31:0] a_mass_out, b_mass_out;
    logic        a_valid_out, b_valid_out, a_busy, b_busy;

    int checks = 0;
    int errors = 0;
    int qx[$];
    int qy[$];

    initial forever #5 clk_in = ~clk_in;

    shadow_centroid dut_a (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (a_x),
        .y_in        (a_y),
        .valid_in    (a_vld),
        .tabulate_in (a_tab),
        .x_out       (a_x_out),
        .y_out       (a_y_out),
        .mass_out    (a_mass_out),
        .valid_out   (a_valid_out),
        .busy_out    (a_busy)
    );

    shadow_centroid #(.MIN_MASS(32'd1)) dut_b (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (b_x),
        .y_in        (b_y),
        .valid_in    (b_vld),
        .tabulate_in (b_tab),
        .x_out       (b_x_out),
        .y_out       (b_y_out),
        .mass_out    (b_mass_out),
        .valid_out   (b_valid_out),
        .busy_out    (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input int vx, input int vy, input bit v, input bit t);
        if (sel) begin
            b_x = 11'(vx); b_y = 10'(vy); b_vld = v; b_tab = t;
        end else begin
            a_x = 11'(vx); a_y = 10'(vy); a_vld = v; a_tab = t;
        end
    endtask

    // Drive the queued pixels into one instance, tabulate, and check the result
    // against the centroid computed from the pixel list.
    task automatic run_frame(input bit sel, input int min_mass, input bit tab_last,
                             input bit noise, input string tag);
        longint sx = 0, sy = 0;
        int m, ex, ey, elat, lat;
        bit seen, vo, bz;
        m = qx.size();
        foreach (qx[i]) begin
            sx += qx[i];
            sy += qy[i];
        end
        if (m < min_mass) begin
            ex = 512; ey = 384; elat = 2;
        end else begin
            ex = int'(sx / m); ey = int'(sy / m); elat = 2 * DIV_LAT + 3;
            if (ex > 2047) ex = 2047;
            if (ey > 1023) ey = 1023;
        end
        for (int i = 0; i < m; i++) begin
            if (i > 0 && $urandom_range(3) == 0) begin
                @(negedge clk_in);
                drive(sel, 0, 0, 1'b0, 1'b0);
            end
            @(negedge clk_in);
            drive(sel, qx[i], qy[i], 1'b1, tab_last && (i == m - 1));
        end
        if (!tab_last || m == 0) begin
            @(negedge clk_in);
            drive(sel, 0, 0, 1'b0, 1'b1);
        end
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= BOUND && !seen; c++) begin
            @(negedge clk_in);
            vo = sel ? b_valid_out : a_valid_out;
            bz = sel ? b_busy : a_busy;
            if (c == 1) drive(sel, 0, 0, 1'b0, 1'b0);
            if (noise && c == 3) chk({tag, "_busy_mid"}, 32'(bz), 32'd1);
            if (noise && c >= 2 && c <= 10)
                drive(sel, int'($urandom_range(2047)), int'($urandom_range(1023)), 1'b1, c == 5);
            if (noise && c == 11) drive(sel, 0, 0, 1'b0, 1'b0);
            if (vo) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        drive(sel, 0, 0, 1'b0, 1'b0);
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(lat), 32'(elat));
            chk({tag, "_x"}, 32'(sel ? b_x_out : a_x_out), 32'(ex));
            chk({tag, "_y"}, 32'(sel ? b_y_out : a_y_out), 32'(ey));
            chk({tag, "_mass"}, sel ? b_mass_out : a_mass_out, 32'(m));
            chk({tag, "_busy_after"}, 32'(sel ? b_busy : a_busy), 32'd0);
            @(negedge clk_in);
            chk({tag, "_pulse_width"}, 32'(sel ? b_valid_out : a_valid_out), 32'd0);
        end
        qx.delete();
        qy.delete();
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) begin
            qx.push_back(int'($urandom_range(2047)));
            qy.push_back(int'($urandom_range(1023)));
        end
    endtask

    initial begin
        int nv;
        rst_in = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 0, 0, 1'b0, 1'b0);
        #1;
        chk("rst_x", 32'(a_x_out), 32'd0);
        chk("rst_y", 32'(a_y_out), 32'd0);
        chk("rst_mass", a_mass_out, 32'd0);
        chk("rst_valid", 32'(a_valid_out), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        // 4x4 block at x 100..103, y 50..53.
        for (int yy = 50; yy <= 53; yy++)
            for (int xx = 100; xx <= 103; xx++) begin
                qx.push_back(xx);
                qy.push_back(yy);
            end
        run_frame(1'b0, 16, 1'b0, 1'b0, "block4x4");

        // Low threshold instance: floor of 10.5.
        qx.push_back(10); qy.push_back(0);
        qx.push_back(11); qy.push_back(0);
        run_frame(1'b1, 1, 1'b0, 1'b0, "minmass1");

        // Below threshold: defaults, short path.
        push_random(5);
        run_frame(1'b0, 16, 1'b0, 1'b0, "lowmass5");

        // Tabulate coincident with the 16th pixel, then a fresh frame.
        push_random(16);
        run_frame(1'b0, 16, 1'b1, 1'b0, "coincident16");
        push_random(20);
        run_frame(1'b0, 16, 1'b0, 1'b0, "after_coincident");

        // Pixels and a stray tabulate while busy must be dropped.
        push_random(18);
        run_frame(1'b0, 16, 1'b0, 1'b1, "busy_noise");
        for (int i = 0; i < 16; i++) begin
            qx.push_back(200);
            qy.push_back(100);
        end
        run_frame(1'b0, 16, 1'b0, 1'b0, "const200_100");

        // Random frames on both instances.
        for (int f = 0; f < 5; f++) begin
            push_random(int'($urandom_range(40)));
            run_frame(1'b0, 16, 1'($urandom_range(1)), 1'b0, "rand_a");
        end
        for (int f = 0; f < 4; f++) begin
            push_random(f == 0 ? 0 : int'($urandom_range(6)));
            run_frame(1'b1, 1, 1'($urandom_range(1)), 1'b0, "rand_b");
        end

        // Reset while the x divide is running.
        push_random(20);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            drive(1'b0, qx[i], qy[i], 1'b1, i == 19);
        end
        @(negedge clk_in);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk_in);
        chk("middiv_busy", 32'(a_busy), 32'd1);
        rst_in = 1'b1;
        #1;
        chk("middiv_x", 32'(a_x_out), 32'd0);
        chk("middiv_y", 32'(a_y_out), 32'd0);
        chk("middiv_mass", a_mass_out, 32'd0);
        chk("middiv_busy_rst", 32'(a_busy), 32'd0);
        qx.delete();
        qy.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        nv = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            if (a_valid_out) nv++;
        end
        chk("middiv_no_valid", 32'(nv), 32'd0);
        push_random(24);
        run_frame(1'b0, 16, 1'b0, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
